// File: rtl/rob_pkg.sv
// Shared AR-channel types for the ROB request/response buffers.
package rob_pkg;

    localparam int unsigned AXI_LEN_W   = 8;
    localparam int unsigned AXI_SIZE_W  = 3;
    localparam int unsigned AXI_BURST_W = 2;
    localparam int unsigned AR_ID_W     = 32;
    localparam int unsigned AR_ADDR_W   = 32;

    // Sized for the widest supported ID/address; narrower instances zero-extend.
    typedef struct packed {
        logic [AR_ID_W-1:0]     id;
        logic [AR_ADDR_W-1:0]   addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
    } ar_entry_t;

endpackage

// File: rtl/incoming_request_buffer_credit.sv
// Outstanding-read counter: +1 per issued AR, -1 per completed burst, sticky underflow flag.
module incoming_request_buffer_credit #(
    parameter int MAX_OUTSTANDING = 16,
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_count,
    output logic             o_credit,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_underflow;
    logic             w_underflow_nxt;

    always_comb begin
        w_count_nxt     = r_count;
        w_underflow_nxt = r_underflow;
        if (i_inc && !i_dec) begin
            if (r_count != CNT_W'(MAX_OUTSTANDING)) begin
                w_count_nxt = r_count + CNT_W'(1);
            end
        end else if (i_dec && !i_inc) begin
            if (r_count == '0) begin
                w_underflow_nxt = 1'b1;
            end else begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign o_count     = r_count;
    assign o_credit    = (r_count != CNT_W'(MAX_OUTSTANDING));
    assign o_underflow = r_underflow;

endmodule

// File: rtl/incoming_request_buffer.sv
// Ingress AR buffer: in-order FIFO with outstanding-read credit limiting.
// Define INCOMING_REQ_BUF_BYPASS_EN to forward ar_in straight to ar_out when empty with credit.
module incoming_request_buffer
    import rob_pkg::*;
#(
    parameter int ID_WIDTH        = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 8,
    parameter int MAX_OUTSTANDING = 16,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_ar_valid,
    output logic                   o_in_ar_ready,
    input  logic [ID_WIDTH-1:0]    i_in_ar_id,
    input  logic [ADDR_WIDTH-1:0]  i_in_ar_addr,
    input  logic [AXI_LEN_W-1:0]   i_in_ar_len,
    input  logic [AXI_SIZE_W-1:0]  i_in_ar_size,
    input  logic [AXI_BURST_W-1:0] i_in_ar_burst,
    output logic                   o_out_ar_valid,
    input  logic                   i_out_ar_ready,
    output logic [ID_WIDTH-1:0]    o_out_ar_id,
    output logic [ADDR_WIDTH-1:0]  o_out_ar_addr,
    output logic [AXI_LEN_W-1:0]   o_out_ar_len,
    output logic [AXI_SIZE_W-1:0]  o_out_ar_size,
    output logic [AXI_BURST_W-1:0] o_out_ar_burst,
    input  logic                   i_rsp_done,
    output logic [OUT_W-1:0]       o_outstanding,
    output logic [CNT_W-1:0]       o_fifo_count,
    output logic                   o_underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    ar_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    ar_entry_t w_in_entry;
    ar_entry_t w_out_entry;
    logic      w_full;
    logic      w_empty;
    logic      w_credit;
    logic      w_bypass;
    logic      w_out_valid;
    logic      w_issue;
    logic      w_push;
    logic      w_pop;

    assign w_full        = (r_count == CNT_W'(DEPTH));
    assign w_empty       = (r_count == '0);
    // Ready is held low through reset even though the FIFO reads as empty.
    assign o_in_ar_ready = ~w_full & i_rst_n;

    always_comb begin
        w_in_entry       = '0;
        w_in_entry.id    = AR_ID_W'(i_in_ar_id);
        w_in_entry.addr  = AR_ADDR_W'(i_in_ar_addr);
        w_in_entry.len   = i_in_ar_len;
        w_in_entry.size  = i_in_ar_size;
        w_in_entry.burst = i_in_ar_burst;
    end

`ifdef INCOMING_REQ_BUF_BYPASS_EN
    assign w_bypass = w_empty & w_credit & i_rst_n;
`else
    assign w_bypass = 1'b0;
`endif

    always_comb begin
        w_out_valid = 1'b0;
        w_out_entry = '0;
        if (w_bypass) begin
            w_out_valid = i_in_ar_valid;
            w_out_entry = w_in_entry;
        end else if (!w_empty) begin
            w_out_valid = w_credit;
            w_out_entry = r_mem[r_rd_ptr];
        end
    end

    assign w_issue = w_out_valid & i_out_ar_ready;
    assign w_pop   = w_issue & ~w_empty;
    // A bypassed beat that is consumed immediately never enters the FIFO.
    assign w_push  = i_in_ar_valid & o_in_ar_ready & ~(w_bypass & i_out_ar_ready);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_entry;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    incoming_request_buffer_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc       (w_issue),
        .i_dec       (i_rsp_done),
        .o_count     (o_outstanding),
        .o_credit    (w_credit),
        .o_underflow (o_underflow_err)
    );

    assign o_out_ar_valid  = w_out_valid;
    assign o_out_ar_id     = w_out_entry.id[ID_WIDTH-1:0];
    assign o_out_ar_addr   = w_out_entry.addr[ADDR_WIDTH-1:0];
    assign o_out_ar_len    = w_out_entry.len;
    assign o_out_ar_size   = w_out_entry.size;
    assign o_out_ar_burst  = w_out_entry.burst;
    assign o_fifo_count    = r_count;

endmodule

// File: tb/tb_incoming_request_buffer.sv
// Directed self-checking bench: default instance plus a MAX_OUTSTANDING=2 instance for credit limits.
module tb_incoming_request_buffer;

    logic        clk;
    logic        rst_n;
    logic        c_rst_n;

    logic        in_valid, in_ready, c_in_valid, c_in_ready;
    logic [31:0] in_id, in_addr;
    logic [7:0]  in_len;
    logic [2:0]  in_size;
    logic [1:0]  in_burst;

    logic        out_valid, out_ready;
    logic [31:0] out_id, out_addr;
    logic [7:0]  out_len;
    logic [2:0]  out_size;
    logic [1:0]  out_burst;
    logic        rsp_done;
    logic [4:0]  outstanding;
    logic [3:0]  fifo_count;
    logic        underflow;

    logic        c_out_valid, c_out_ready;
    logic [31:0] c_out_id, c_out_addr;
    logic [7:0]  c_out_len;
    logic [2:0]  c_out_size;
    logic [1:0]  c_out_burst;
    logic        c_rsp_done;
    logic [1:0]  c_outstanding;
    logic [3:0]  c_fifo_count;
    logic        c_underflow;

    int n_vec;
    int n_err;

    incoming_request_buffer dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_in_ar_valid  (in_valid),
        .o_in_ar_ready  (in_ready),
        .i_in_ar_id     (in_id),
        .i_in_ar_addr   (in_addr),
        .i_in_ar_len    (in_len),
        .i_in_ar_size   (in_size),
        .i_in_ar_burst  (in_burst),
        .o_out_ar_valid (out_valid),
        .i_out_ar_ready (out_ready),
        .o_out_ar_id    (out_id),
        .o_out_ar_addr  (out_addr),
        .o_out_ar_len   (out_len),
        .o_out_ar_size  (out_size),
        .o_out_ar_burst (out_burst),
        .i_rsp_done     (rsp_done),
        .o_outstanding  (outstanding),
        .o_fifo_count   (fifo_count),
        .o_underflow_err(underflow)
    );

    incoming_request_buffer #(
        .MAX_OUTSTANDING(2)
    ) dut_c (
        .i_clk          (clk),
        .i_rst_n        (c_rst_n),
        .i_in_ar_valid  (c_in_valid),
        .o_in_ar_ready  (c_in_ready),
        .i_in_ar_id     (in_id),
        .i_in_ar_addr   (in_addr),
        .i_in_ar_len    (in_len),
        .i_in_ar_size   (in_size),
        .i_in_ar_burst  (in_burst),
        .o_out_ar_valid (c_out_valid),
        .i_out_ar_ready (c_out_ready),
        .o_out_ar_id    (c_out_id),
        .o_out_ar_addr  (c_out_addr),
        .o_out_ar_len   (c_out_len),
        .o_out_ar_size  (c_out_size),
        .o_out_ar_burst (c_out_burst),
        .i_rsp_done     (c_rsp_done),
        .o_outstanding  (c_outstanding),
        .o_fifo_count   (c_fifo_count),
        .o_underflow_err(c_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_in(input logic v, input logic [31:0] id);
        in_valid = v;
        in_id    = id;
        in_addr  = 32'h1000 + (id << 4);
        in_len   = id[7:0];
        in_size  = 3'd2;
        in_burst = 2'b01;
    endtask

    task automatic retire(input int n);
        rsp_done = 1'b1;
        repeat (n) @(negedge clk);
        rsp_done = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_vec++; if (fifo_count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", fifo_count); end
        n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL reset_outst got %0d want 0", outstanding); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", in_ready); end
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_uflow got %b want 0", underflow); end
        n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL reset_c_valid got %b want 0", c_out_valid); end
        @(negedge clk);
        rst_n   = 1'b1;
        c_rst_n = 1'b1;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_ready got %b want 1", in_ready); end
    endtask

    task automatic test_fill;
        out_ready = 1'b0;
        set_in(1'b1, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_vec++; if (fifo_count !== 4'(k + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", k, fifo_count, k + 1); end
            n_vec++; if (out_valid !== 1'b1 || out_id !== 32'd0) begin n_err++; $display("FAIL fill_head[%0d] got v=%b id=%0h want v=1 id=0", k, out_valid, out_id); end
            if (k < 7) set_in(1'b1, 32'(k + 1));
            else set_in(1'b1, 32'd99);
        end
        n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_ready got %b want 0", in_ready); end
        @(negedge clk);
        n_vec++; if (fifo_count !== 4'd8) begin n_err++; $display("FAIL full_hold got %0d want 8", fifo_count); end
        set_in(1'b0, 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_vec++; if (out_valid !== 1'b1 || out_id !== 32'(k)) begin n_err++; $display("FAIL drain_id[%0d] got v=%b id=%0h want v=1 id=%0h", k, out_valid, out_id, k); end
            n_vec++; if (out_addr !== 32'h1000 + 32'(k * 16) || out_len !== 8'(k)) begin n_err++; $display("FAIL drain_fields[%0d] got addr=%0h len=%0d", k, out_addr, out_len); end
            @(negedge clk);
        end
        n_vec++; if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty got cnt=%0d v=%b want 0 0", fifo_count, out_valid); end
        n_vec++; if (out_id !== 32'd0) begin n_err++; $display("FAIL empty_fields got id=%0h want 0", out_id); end
        n_vec++; if (outstanding !== 5'd8) begin n_err++; $display("FAIL drain_outst got %0d want 8", outstanding); end
        out_ready = 1'b0;
        retire(8);
        n_vec++; if (outstanding !== 5'd0) begin n_err++; $display("FAIL retire_outst got %0d want 0", outstanding); end
    endtask

    task automatic test_simultaneous;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h20 + 32'(k));
            @(negedge clk);
        end
        n_vec++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL sim_prefill got %0d want 4", fifo_count); end
        set_in(1'b1, 32'h24);
        out_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            n_vec++; if (fifo_count !== 4'd4) begin n_err++; $display("FAIL sim_count[%0d] got %0d want 4", j, fifo_count); end
            n_vec++; if (out_id !== 32'h21 + 32'(j)) begin n_err++; $display("FAIL sim_head[%0d] got %0h want %0h", j, out_id, 32'h21 + j); end
            set_in(1'b1, 32'h25 + 32'(j));
        end
        n_vec++; if (outstanding !== 5'd5) begin n_err++; $display("FAIL sim_outst got %0d want 5", outstanding); end
        set_in(1'b0, 32'd0);
        rsp_done = 1'b1;
        @(negedge clk);
        rsp_done = 1'b0;
        n_vec++; if (outstanding !== 5'd5) begin n_err++; $display("FAIL pop_rsp_outst got %0d want 5", outstanding); end
        n_vec++; if (fifo_count !== 4'd3 || out_id !== 32'h26) begin n_err++; $display("FAIL pop_rsp_fifo got cnt=%0d id=%0h want 3 26", fifo_count, out_id); end
        repeat (3) @(negedge clk);
        n_vec++; if (outstanding !== 5'd8 || fifo_count !== 4'd0) begin n_err++; $display("FAIL sim_drain got outst=%0d cnt=%0d want 8 0", outstanding, fifo_count); end
        out_ready = 1'b0;
        retire(8);
    endtask

    task automatic test_latency;
        set_in(1'b1, 32'h5);
        out_ready = 1'b1;
        #1;
`ifdef INCOMING_REQ_BUF_BYPASS_EN
        n_vec++; if (out_valid !== 1'b1 || out_id !== 32'h5) begin n_err++; $display("FAIL bypass_same_cycle got v=%b id=%0h want v=1 id=5", out_valid, out_id); end
        @(negedge clk);
        set_in(1'b0, 32'd0);
`else
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL no_bypass got v=%b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || out_id !== 32'h5 || fifo_count !== 4'd1) begin n_err++; $display("FAIL latency1 got v=%b id=%0h cnt=%0d want 1 5 1", out_valid, out_id, fifo_count); end
        set_in(1'b0, 32'd0);
        @(negedge clk);
`endif
        n_vec++; if (fifo_count !== 4'd0 || outstanding !== 5'd1) begin n_err++; $display("FAIL issue_state got cnt=%0d outst=%0d want 0 1", fifo_count, outstanding); end
        out_ready = 1'b0;
        retire(1);
    endtask

    task automatic test_credit;
        c_out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 32'h40 + 32'(k));
            c_in_valid = 1'b1;
            @(negedge clk);
        end
        c_in_valid = 1'b0;
        n_vec++; if (c_fifo_count !== 4'd3) begin n_err++; $display("FAIL credit_fill got %0d want 3", c_fifo_count); end
        c_out_ready = 1'b1;
        #1;
        n_vec++; if (c_out_valid !== 1'b1 || c_out_id !== 32'h40) begin n_err++; $display("FAIL credit_first got v=%b id=%0h want 1 40", c_out_valid, c_out_id); end
        @(negedge clk);
        n_vec++; if (c_outstanding !== 2'd1 || c_out_valid !== 1'b1 || c_out_id !== 32'h41) begin n_err++; $display("FAIL credit_second got o=%0d v=%b id=%0h want 1 1 41", c_outstanding, c_out_valid, c_out_id); end
        @(negedge clk);
        n_vec++; if (c_outstanding !== 2'd2 || c_out_valid !== 1'b0 || c_fifo_count !== 4'd1) begin n_err++; $display("FAIL credit_block got o=%0d v=%b cnt=%0d want 2 0 1", c_outstanding, c_out_valid, c_fifo_count); end
        @(negedge clk);
        n_vec++; if (c_out_valid !== 1'b0) begin n_err++; $display("FAIL credit_hold got v=%b want 0", c_out_valid); end
        c_rsp_done = 1'b1;
        @(negedge clk);
        c_rsp_done = 1'b0;
        n_vec++; if (c_outstanding !== 2'd1 || c_out_valid !== 1'b1 || c_out_id !== 32'h42) begin n_err++; $display("FAIL credit_resume got o=%0d v=%b id=%0h want 1 1 42", c_outstanding, c_out_valid, c_out_id); end
        @(negedge clk);
        n_vec++; if (c_outstanding !== 2'd2 || c_fifo_count !== 4'd0 || c_out_valid !== 1'b0) begin n_err++; $display("FAIL credit_third got o=%0d cnt=%0d v=%b want 2 0 0", c_outstanding, c_fifo_count, c_out_valid); end
        c_out_ready = 1'b0;
        c_rsp_done  = 1'b1;
        repeat (2) @(negedge clk);
        c_rsp_done  = 1'b0;
        n_vec++; if (c_outstanding !== 2'd0 || c_underflow !== 1'b0) begin n_err++; $display("FAIL credit_retire got o=%0d uf=%b want 0 0", c_outstanding, c_underflow); end
    endtask

    task automatic test_underflow;
        n_vec++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uflow_pre got %b want 0", underflow); end
        rsp_done = 1'b1;
        @(negedge clk);
        rsp_done = 1'b0;
        n_vec++; if (outstanding !== 5'd0 || underflow !== 1'b1) begin n_err++; $display("FAIL uflow_set got o=%0d uf=%b want 0 1", outstanding, underflow); end
        @(negedge clk);
        n_vec++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uflow_sticky got %b want 1", underflow); end
    endtask

    task automatic test_reset_mid_traffic;
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, 32'h60 + 32'(k));
            @(negedge clk);
        end
        set_in(1'b0, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_vec++; if (fifo_count !== 4'd3 || outstanding !== 5'd1) begin n_err++; $display("FAIL mid_pre got cnt=%0d o=%0d want 3 1", fifo_count, outstanding); end
        set_in(1'b1, 32'h70);
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (fifo_count !== 4'd0 || outstanding !== 5'd0) begin n_err++; $display("FAIL mid_rst_cnt got cnt=%0d o=%0d want 0 0", fifo_count, outstanding); end
        n_vec++; if (out_valid !== 1'b0 || out_id !== 32'd0) begin n_err++; $display("FAIL mid_rst_out got v=%b id=%0h want 0 0", out_valid, out_id); end
        n_vec++; if (in_ready !== 1'b0 || underflow !== 1'b0) begin n_err++; $display("FAIL mid_rst_flags got rdy=%b uf=%b want 0 0", in_ready, underflow); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (out_valid !== 1'b0 || fifo_count !== 4'd0) begin n_err++; $display("FAIL post_rst_empty got v=%b cnt=%0d want 0 0", out_valid, fifo_count); end
        @(negedge clk);
        set_in(1'b0, 32'd0);
        n_vec++; if (fifo_count !== 4'd1 || out_id !== 32'h70) begin n_err++; $display("FAIL post_rst_push got cnt=%0d id=%0h want 1 70", fifo_count, out_id); end
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        c_rst_n     = 1'b0;
        c_in_valid  = 1'b0;
        out_ready   = 1'b0;
        c_out_ready = 1'b0;
        rsp_done    = 1'b0;
        c_rsp_done  = 1'b0;
        set_in(1'b0, 32'd0);
        test_reset;
        test_fill;
        test_simultaneous;
        test_latency;
        test_credit;
        test_underflow;
        test_reset_mid_traffic;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
